// File: rtl/calc_host_master.sv
// Command initiator for the dev_fsm calculator: serialises a latched request onto cs/din,
// then waits for drdy (with timeout) and hands the result back over a valid/ready channel.
module calc_host_master #(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic [DW-1:0] req_cmd,
    input  logic [DW-1:0] req_op1,
    input  logic [DW-1:0] req_op2,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,

    output logic          cs,
    output logic [DW-1:0] din,
    input  logic          busy,
    input  logic [DW-1:0] dout,
    input  logic          drdy
);

    // Command bit positions shared with dev_fsm (cmd_bits).
    localparam int unsigned b_subres = 0;
    localparam int unsigned b_addres = 1;
    localparam int unsigned b_subop  = 2;
    localparam int unsigned b_addop  = 3;
    localparam int unsigned b_op_2   = 4;
    localparam int unsigned b_tx     = 5;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBusy,
        StCmd,
        StOp1,
        StOp2,
        StWaitRdy,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] cmd_q, op1_q, op2_q;
    logic [TW-1:0] cnt_q;
    logic          need_op1, need_op2, need_rx;
    logic          rdy_timeout;

    assign need_op1 = cmd_q[b_subres] | cmd_q[b_addres] | cmd_q[b_subop] | cmd_q[b_addop];
    assign need_op2 = cmd_q[b_op_2];
    assign need_rx  = cmd_q[b_tx];

    assign rdy_timeout = (cnt_q == TW'(TIMEOUT - 1));

    // Held low throughout reset even though the state register already reads idle.
    assign req_ready = (state_q == StIdle) && !rst;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!busy) state_d = StCmd;
            end
            StCmd: begin
                if (need_op1)      state_d = StOp1;
                else if (need_op2) state_d = StOp2;
                else if (need_rx)  state_d = StWaitRdy;
                else               state_d = StIdle;
            end
            StOp1: begin
                if (need_op2)     state_d = StOp2;
                else if (need_rx) state_d = StWaitRdy;
                else              state_d = StIdle;
            end
            StOp2: begin
                state_d = need_rx ? StWaitRdy : StIdle;
            end
            StWaitRdy: begin
                if (drdy || rdy_timeout) state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            cnt_q     <= '0;
            cs        <= 1'b0;
            din       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == StIdle && req_valid) begin
                cmd_q <= req_cmd;
                op1_q <= req_op1;
                op2_q <= req_op2;
            end

            cs <= (state_d == StCmd);
            unique case (state_d)
                StCmd:   din <= cmd_q;
                StOp1:   din <= op1_q;
                StOp2:   din <= op2_q;
                default: din <= '0;
            endcase

            if (state_q != StWaitRdy) begin
                cnt_q <= '0;
            end else if (!drdy) begin
                cnt_q <= cnt_q + TW'(1);
            end

            if (state_q == StWaitRdy && state_d == StResp) begin
                rsp_data <= drdy ? dout : '0;
                rsp_err  <= !drdy;
            end

            rsp_valid <= (state_d == StResp);
        end
    end

endmodule
